result_display: RTL and testbench
=================================

# result_display

Reads back a signed 16-bit two's-complement word (a BRAM result or operand written by the button input path) and renders it on the 4-digit 7-segment display. A sequential double-dabble converter produces sign plus BCD digits, one shift per clock. A time-multiplexer then drives the sign and three digits onto the shared segment lines. The BCD digit outputs are also exported so other blocks can reuse them.

## Interface
- REFRESH_DIV, 100000: clk cycles each digit stays lit. The default gives 1 ms per digit at 100 MHz. The minimum legal value is 2.
- clk  in  1  system clock, 100 MHz.
- reset  in  1  synchronous, active-low reset, sampled on posedge clk.
- data_in  in  16  signed two's-complement value to display.
- data_valid  in  1  load strobe, sampled only while idle.
- busy  out  1  conversion in progress.
- done  out  1  one-cycle pulse when new digits are registered.
- sign_out  out  1  1 = last converted value negative.
- overflow_out  out  1  1 = magnitude > 999.
- ones_out, tens_out, hundreds_out, thousands_out  out  4 each  BCD digits of the magnitude.
- seg  out  7  active-low segments {g,f,e,d,c,b,a}.
- an  out  4  active-low anodes; an[0] is the rightmost digit.

## Operation
- **FSM states:** IDLE, SHIFT, DONE.
- **IDLE:**
  - When data_valid=1, capture mag = data_in[15] ? -data_in : data_in as 16-bit unsigned. -32768 gives 32768, with no loss.
  - Capture neg = data_in[15].
  - Clear the 20-bit BCD scratch (5 digits). Set bit counter = 0. Go to SHIFT.
- **SHIFT (16 cycles):**
  - For each BCD nibble >= 5, add 3.
  - Then shift {bcd, mag} left by 1.
  - Increment the counter. After the 16th shift, go to DONE.
- **DONE (1 cycle):**
  - Register ones..thousands from the scratch.
  - sign_out = neg, except a value of 0 always gives sign_out = 0.
  - overflow_out = (ten-thousands != 0) | (thousands != 0).
  - Pulse done. Return to IDLE.
- busy = 1 in SHIFT and DONE.
- data_valid outside IDLE is ignored and is not queued.
- Digit outputs hold the last completed conversion. They never show partial results.
- **Display mux:**
  - A refresh counter counts 0..REFRESH_DIV-1. On wrap, digit index 0→1→2→3→0 advances.
  - Index i drives an[i] = 0 and all other anodes = 1.
  - Index 0/1/2 shows ones/tens/hundreds.
  - Index 3 shows '-' if sign_out, otherwise blank.
- **Overflow display:** when overflow_out = 1, index 3 shows 'E' and indices 0–2 show '-'.
- **Segment codes:**
  - Digits 0–9: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.
  - '-' = 0111111, blank = 1111111, 'E' = 0000110.
- The mux runs continuously and independently of the FSM.

## Timing
- **Reset (reset=0 at posedge):**
  - State = IDLE.
  - busy = done = sign_out = overflow_out = 0, and all BCD outputs = 0.
  - Refresh counter = 0 and digit index = 0, so an = 1110 and seg = 1000000.
- Reset during SHIFT or DONE aborts the conversion. No done pulse is produced.
- **Latency:**
  - data_valid sampled at edge E0.
  - busy = 1 after E0.
  - Shifts occur at E1..E16.
  - DONE is entered after E16.
  - At E17, digits update, done = 1 for the cycle following E17, and busy = 0 after E17.
  - data_valid accepted at E17 if state is IDLE at that edge.
- **Back-to-back:** the next data_valid is accepted at the edge where the FSM is in IDLE, giving a minimum spacing of 18 cycles.
- seg and an are registered outputs. Both change on the same edge the digit index advances.

## Test plan
- Reset held 3 cycles, then released -> an = 1110, seg = 1000000, busy = 0, all digits 0.
- data_in = 123 (0x007B), data_valid pulse -> done exactly 17 cycles later. Outputs: hundreds = 1, tens = 2, ones = 3, sign_out = 0, overflow_out = 0.
- data_in = -456 (0xFE38) with REFRESH_DIV = 4 -> sign_out = 1. Over 16 cycles an cycles 1110, 1101, 1011, 0111 with seg 0000010, 0010010, 0011001, 0111111.
- data_in = -32768 (0x8000) -> thousands = 2, ones = 8, overflow_out = 1, sign_out = 1. Display shows 'E','-','-','-'.
- data_valid re-pulsed with 0x0001 at cycle 5 of a conversion of 42 -> ignored. Final digits are 042 and only one done pulse occurs.
- reset = 0 at cycle 8 of a conversion of 999 -> no done pulse, all outputs return to reset values. The next conversion of 7 completes normally.

Source files
------------

// File: rtl/result_display.sv
// Signed 16-bit word to 4-digit 7-segment display: sequential double-dabble
// converter (one shift per clock) feeding a continuously running digit multiplexer.
module result_display #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] data_in,
    input  logic        data_valid,
    output logic        busy,
    output logic        done,
    output logic        sign_out,
    output logic        overflow_out,
    output logic [3:0]  ones_out,
    output logic [3:0]  tens_out,
    output logic [3:0]  hundreds_out,
    output logic [3:0]  thousands_out,
    output logic [6:0]  seg,
    output logic [3:0]  an
);

    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam int unsigned CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t      state, state_next;
    logic [15:0] mag;
    logic [19:0] bcd;
    logic [19:0] bcd_adj;
    logic        neg;
    logic [3:0]  bit_cnt;

    function automatic logic [6:0] digit_seg(input logic [3:0] d);
        case (d)
            4'd0:    digit_seg = 7'b1000000;
            4'd1:    digit_seg = 7'b1111001;
            4'd2:    digit_seg = 7'b0100100;
            4'd3:    digit_seg = 7'b0110000;
            4'd4:    digit_seg = 7'b0011001;
            4'd5:    digit_seg = 7'b0010010;
            4'd6:    digit_seg = 7'b0000010;
            4'd7:    digit_seg = 7'b1111000;
            4'd8:    digit_seg = 7'b0000000;
            4'd9:    digit_seg = 7'b0010000;
            default: digit_seg = SEG_BLANK;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (data_valid) state_next = SHIFT;
            SHIFT:   if (bit_cnt == 4'd15) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Add-3 correction applied to every nibble before each shift.
    always_comb begin
        bcd_adj = bcd;
        for (int unsigned i = 0; i < 5; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            mag           <= '0;
            bcd           <= '0;
            neg           <= 1'b0;
            bit_cnt       <= '0;
            done          <= 1'b0;
            sign_out      <= 1'b0;
            overflow_out  <= 1'b0;
            ones_out      <= '0;
            tens_out      <= '0;
            hundreds_out  <= '0;
            thousands_out <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (data_valid) begin
                        mag     <= data_in[15] ? (~data_in + 16'd1) : data_in;
                        neg     <= data_in[15];
                        bcd     <= '0;
                        bit_cnt <= '0;
                    end
                end
                SHIFT: begin
                    {bcd, mag} <= {bcd_adj, mag} << 1;
                    bit_cnt    <= bit_cnt + 4'd1;
                end
                DONE: begin
                    ones_out      <= bcd[3:0];
                    tens_out      <= bcd[7:4];
                    hundreds_out  <= bcd[11:8];
                    thousands_out <= bcd[15:12];
                    sign_out      <= neg & (bcd != '0);
                    overflow_out  <= (bcd[19:16] != 4'd0) | (bcd[15:12] != 4'd0);
                    done          <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    logic [CW-1:0] refresh_cnt;
    logic [1:0]    digit_idx, idx_next;
    logic          wrap;
    logic [6:0]    seg_next;

    assign wrap     = (refresh_cnt == CW'(REFRESH_DIV - 1));
    assign idx_next = wrap ? digit_idx + 2'd1 : digit_idx;

    // seg/an are decoded from the upcoming index so they switch with it.
    always_comb begin
        seg_next = SEG_BLANK;
        case (idx_next)
            2'd0: seg_next = overflow_out ? SEG_DASH : digit_seg(ones_out);
            2'd1: seg_next = overflow_out ? SEG_DASH : digit_seg(tens_out);
            2'd2: seg_next = overflow_out ? SEG_DASH : digit_seg(hundreds_out);
            2'd3: seg_next = overflow_out ? SEG_E : (sign_out ? SEG_DASH : SEG_BLANK);
            default: seg_next = SEG_BLANK;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            refresh_cnt <= '0;
            digit_idx   <= '0;
            an          <= 4'b1110;
            seg         <= 7'b1000000;
        end else begin
            refresh_cnt <= wrap ? '0 : refresh_cnt + CW'(1);
            digit_idx   <= idx_next;
            an          <= ~(4'b0001 << idx_next);
            seg         <= seg_next;
        end
    end

endmodule

// File: tb/tb_result_display.sv
// Directed self-checking bench for result_display with a short refresh period.
module tb_result_display;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] data_in = '0;
    logic        data_valid = 1'b0;
    logic        busy, done, sign_out, overflow_out;
    logic [3:0]  ones_out, tens_out, hundreds_out, thousands_out;
    logic [6:0]  seg;
    logic [3:0]  an;

    int checks = 0;
    int passes = 0;
    int n;
    int dones;

    result_display #(.REFRESH_DIV(4)) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
        .busy(busy), .done(done), .sign_out(sign_out), .overflow_out(overflow_out),
        .ones_out(ones_out), .tens_out(tens_out), .hundreds_out(hundreds_out),
        .thousands_out(thousands_out), .seg(seg), .an(an)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic start(input logic [15:0] v);
        @(negedge clk);
        data_in = v;
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            cyc++;
            if (done) break;
        end
    endtask

    task automatic wait_an0();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (an == 4'b1110) break;
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_an", an, 4'b1110);
        check("rst_seg", seg, 7'b1000000);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_digits", {thousands_out, hundreds_out, tens_out, ones_out}, 16'h0000);
        check("rst_flags", {sign_out, overflow_out}, 2'b00);
        reset = 1'b1;

        start(16'h007B);
        check("p123_busy", busy, 1);
        wait_done(n);
        check("p123_latency", n, 17);
        check("p123_digits", {thousands_out, hundreds_out, tens_out, ones_out}, 16'h0123);
        check("p123_flags", {sign_out, overflow_out}, 2'b00);
        @(negedge clk);
        check("p123_pulse", {done, busy}, 2'b00);

        start(16'hFE38);
        wait_done(n);
        check("n456_digits", {thousands_out, hundreds_out, tens_out, ones_out}, 16'h0456);
        check("n456_flags", {sign_out, overflow_out}, 2'b10);
        repeat (2) @(negedge clk);
        wait_an0();
        check("n456_an0", an, 4'b1110);
        check("n456_seg0", seg, 7'b0000010);
        repeat (4) @(negedge clk);
        check("n456_an1", an, 4'b1101);
        check("n456_seg1", seg, 7'b0010010);
        repeat (4) @(negedge clk);
        check("n456_an2", an, 4'b1011);
        check("n456_seg2", seg, 7'b0011001);
        repeat (4) @(negedge clk);
        check("n456_an3", an, 4'b0111);
        check("n456_seg3", seg, 7'b0111111);

        start(16'h8000);
        wait_done(n);
        check("min_digits", {thousands_out, hundreds_out, tens_out, ones_out}, 16'h2768);
        check("min_flags", {sign_out, overflow_out}, 2'b11);
        repeat (2) @(negedge clk);
        wait_an0();
        check("min_seg0", seg, 7'b0111111);
        repeat (4) @(negedge clk);
        check("min_seg1", seg, 7'b0111111);
        repeat (4) @(negedge clk);
        check("min_seg2", seg, 7'b0111111);
        repeat (4) @(negedge clk);
        check("min_an3", an, 4'b0111);
        check("min_seg3", seg, 7'b0000110);

        start(16'h0000);
        wait_done(n);
        check("zero_digits", {thousands_out, hundreds_out, tens_out, ones_out}, 16'h0000);
        check("zero_flags", {sign_out, overflow_out}, 2'b00);

        start(16'd42);
        repeat (4) @(negedge clk);
        data_in = 16'h0001;
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("ign_dones", dones, 1);
        check("ign_digits", {thousands_out, hundreds_out, tens_out, ones_out}, 16'h0042);

        start(16'd999);
        repeat (7) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("abort_busy_done", {busy, done}, 2'b00);
        check("abort_digits", {thousands_out, hundreds_out, tens_out, ones_out}, 16'h0000);
        check("abort_flags", {sign_out, overflow_out}, 2'b00);
        check("abort_an", an, 4'b1110);
        check("abort_seg", seg, 7'b1000000);
        reset = 1'b1;
        dones = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("abort_no_done", dones, 0);

        start(16'd7);
        wait_done(n);
        check("p7_latency", n, 17);
        check("p7_digits", {thousands_out, hundreds_out, tens_out, ones_out}, 16'h0007);
        check("p7_flags", {sign_out, overflow_out}, 2'b00);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
